// File: rtl/axis_adder_fifo.sv
// Two-operand stream adder: joins two valid/ready operand streams, buffers the
// WIDTH+1-bit sums in a DEPTH-entry FIFO and presents them on a valid/ready output.
module axis_adder_fifo #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned DEPTH  = 4,
    parameter bit          SIGNED = 1'b0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             data1_valid_i,
    output logic                             data1_ready_o,
    input  logic [WIDTH-1:0]                 data1_i,
    input  logic                             data2_valid_i,
    output logic                             data2_ready_o,
    input  logic [WIDTH-1:0]                 data2_i,
    output logic                             data_valid_o,
    input  logic                             data_ready_i,
    output logic [WIDTH:0]                   data_o,
    output logic [$clog2(DEPTH+1)-1:0]       count_o
);

    localparam int unsigned SUM_W = WIDTH + 1;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [SUM_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next;
    logic [CNT_W-1:0] count_next;
    logic [SUM_W-1:0] op1_ext;
    logic [SUM_W-1:0] op2_ext;
    logic [SUM_W-1:0] sum;
    logic             full;
    logic             push;
    logic             pop;
    logic             head_is_new;

    // Operand join: each side is ready only when the other side has data to pair with.
    assign full          = (count_o == CNT_W'(DEPTH));
    assign data1_ready_o = data2_valid_i & ~full & ~reset;
    assign data2_ready_o = data1_valid_i & ~full & ~reset;
    assign push          = data1_valid_i & data2_valid_i & ~full & ~reset;
    assign data_valid_o  = (count_o != '0);
    assign pop           = data_valid_o & data_ready_i;

    assign op1_ext = {SIGNED & data1_i[WIDTH-1], data1_i};
    assign op2_ext = {SIGNED & data2_i[WIDTH-1], data2_i};
    assign sum     = op1_ext + op2_ext;

    // The pushed sum becomes the head when nothing older remains after this edge.
    assign head_is_new = push & ((count_o == '0) | ((count_o == CNT_W'(1)) & pop));

    always_comb begin
        count_next = count_o;
        rd_next    = rd_ptr;
        if (pop) begin
            rd_next = rd_ptr + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_next = count_o + CNT_W'(1);
            2'b01:   count_next = count_o - CNT_W'(1);
            default: count_next = count_o;
        endcase
    end

    // Storage array, no reset needed: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sum;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
            data_o  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr  <= rd_next;
            count_o <= count_next;
            // Registered head: holds its last value while the buffer is empty.
            if (count_next != '0) begin
                data_o <= head_is_new ? sum : mem[rd_next];
            end
        end
    end

endmodule

// File: tb/tb_axis_adder_fifo.sv
// Directed self-checking bench for axis_adder_fifo; an unsigned and a signed
// instance share stimulus so sign-extension differences are visible side by side.
module tb_axis_adder_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       d1_valid, d2_valid, out_ready;
    logic [3:0] d1, d2;
    logic       r1_u, r2_u, v_u, r1_s, r2_s, v_s;
    logic [4:0] q_u, q_s;
    logic [2:0] cnt_u, cnt_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axis_adder_fifo #(.WIDTH(4), .DEPTH(4), .SIGNED(1'b0)) dut_u (
        .clk(clk), .reset(reset),
        .data1_valid_i(d1_valid), .data1_ready_o(r1_u), .data1_i(d1),
        .data2_valid_i(d2_valid), .data2_ready_o(r2_u), .data2_i(d2),
        .data_valid_o(v_u), .data_ready_i(out_ready), .data_o(q_u), .count_o(cnt_u)
    );

    axis_adder_fifo #(.WIDTH(4), .DEPTH(4), .SIGNED(1'b1)) dut_s (
        .clk(clk), .reset(reset),
        .data1_valid_i(d1_valid), .data1_ready_o(r1_s), .data1_i(d1),
        .data2_valid_i(d2_valid), .data2_ready_o(r2_s), .data2_i(d2),
        .data_valid_o(v_s), .data_ready_i(out_ready), .data_o(q_s), .count_o(cnt_s)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v1, input logic [3:0] a, input logic v2,
                         input logic [3:0] b, input logic rdy);
        d1_valid  = v1;
        d1        = a;
        d2_valid  = v2;
        d2        = b;
        out_ready = rdy;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 4'd1, 1'b1, 4'd2, 1'b1);
        for (int i = 0; i < 3; i++) step();
        checks++;
        if ({v_u, cnt_u, q_u, r1_u, r2_u} !== 11'd0) begin
            errors++;
            $display("FAIL reset_u: valid=%b count=%0d data=%0d r1=%b r2=%b, want all 0",
                     v_u, cnt_u, q_u, r1_u, r2_u);
        end
        checks++;
        if ({v_s, cnt_s, q_s, r1_s, r2_s} !== 11'd0) begin
            errors++;
            $display("FAIL reset_s: valid=%b count=%0d data=%0d r1=%b r2=%b, want all 0",
                     v_s, cnt_s, q_s, r1_s, r2_s);
        end
        drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        reset = 1'b0;
        step();
    endtask

    task automatic test_unsigned_add();
        drive(1'b1, 4'd15, 1'b1, 4'd15, 1'b1);
        checks++;
        if ({r1_u, r2_u} !== 2'b11) begin
            errors++;
            $display("FAIL add_ready: got %b%b want 11", r1_u, r2_u);
        end
        step();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
        checks++;
        if (v_u !== 1'b1 || q_u !== 5'd30 || cnt_u !== 3'd1) begin
            errors++;
            $display("FAIL add_15_15: valid=%b data=%0d count=%0d, want 1/30/1", v_u, q_u, cnt_u);
        end
        step();
        checks++;
        if (v_u !== 1'b0 || cnt_u !== 3'd0 || q_u !== 5'd30) begin
            errors++;
            $display("FAIL add_drain: valid=%b count=%0d data=%0d, want 0/0/30 held", v_u, cnt_u, q_u);
        end
    endtask

    task automatic test_signed_add();
        drive(1'b1, 4'd8, 1'b1, 4'd8, 1'b1);
        step();
        drive(1'b1, 4'd7, 1'b1, 4'd15, 1'b1);
        checks++;
        if (q_s !== 5'b10000 || v_s !== 1'b1) begin
            errors++;
            $display("FAIL signed_m8_m8: data=%b valid=%b, want 10000/1", q_s, v_s);
        end
        step();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
        checks++;
        if (q_s !== 5'd6 || cnt_s !== 3'd1) begin
            errors++;
            $display("FAIL signed_7_m1: data=%0d count=%0d, want 6/1", q_s, cnt_s);
        end
        checks++;
        if (q_u !== 5'd22) begin
            errors++;
            $display("FAIL unsigned_7_15: data=%0d, want 22", q_u);
        end
        step();
    endtask

    task automatic test_join();
        int bad;
        bad = 0;
        drive(1'b1, 4'd3, 1'b0, 4'd4, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (r1_u !== 1'b0 || r2_u !== 1'b1 || cnt_u !== 3'd0) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL join_one_side: %0d bad cycles, last r1=%b r2=%b count=%0d, want 0/1/0",
                     bad, r1_u, r2_u, cnt_u);
        end
        drive(1'b1, 4'd3, 1'b1, 4'd4, 1'b0);
        step();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        step();
        checks++;
        if (cnt_u !== 3'd1 || q_u !== 5'd7 || v_u !== 1'b1) begin
            errors++;
            $display("FAIL join_pair: count=%0d data=%0d valid=%b, want 1/7/1", cnt_u, q_u, v_u);
        end
        drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
        step();
    endtask

    task automatic test_full_and_drain();
        logic [4:0] exp_head [6] = '{5'd3, 5'd5, 5'd7, 5'd9, 5'd11, 5'd13};
        logic [2:0] exp_cnt  [6] = '{3'd4, 3'd3, 3'd3, 3'd3, 3'd2, 3'd1};
        // Offer pairs (k, k+1), k=1..4, with the consumer stalled.
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 4'(k), 1'b1, 4'(k + 1), 1'b0);
            step();
        end
        drive(1'b1, 4'd5, 1'b1, 4'd6, 1'b0);
        step();
        checks++;
        if (cnt_u !== 3'd4 || r1_u !== 1'b0 || r2_u !== 1'b0 || q_u !== 5'd3) begin
            errors++;
            $display("FAIL full_stall: count=%0d r1=%b r2=%b head=%0d, want 4/0/0/3",
                     cnt_u, r1_u, r2_u, q_u);
        end
        for (int i = 0; i < 6; i++) begin
            if (i == 2) drive(1'b1, 4'd6, 1'b1, 4'd7, 1'b1);
            else if (i >= 3) drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
            else drive(1'b1, 4'd5, 1'b1, 4'd6, 1'b1);
            checks++;
            if (q_u !== exp_head[i] || cnt_u !== exp_cnt[i] || v_u !== 1'b1) begin
                errors++;
                $display("FAIL drain_%0d: head=%0d count=%0d valid=%b, want %0d/%0d/1",
                         i, q_u, cnt_u, v_u, exp_head[i], exp_cnt[i]);
            end
            step();
        end
        checks++;
        if (cnt_u !== 3'd0 || v_u !== 1'b0 || q_u !== 5'd13) begin
            errors++;
            $display("FAIL drain_end: count=%0d valid=%b data=%0d, want 0/0/13", cnt_u, v_u, q_u);
        end
    endtask

    task automatic test_back_to_back_and_reset();
        drive(1'b1, 4'd1, 1'b1, 4'd1, 1'b0);
        step();
        drive(1'b1, 4'd2, 1'b1, 4'd2, 1'b0);
        step();
        drive(1'b1, 4'd3, 1'b1, 4'd3, 1'b1);
        checks++;
        if (cnt_u !== 3'd2 || q_u !== 5'd2) begin
            errors++;
            $display("FAIL pre_pushpop: count=%0d head=%0d, want 2/2", cnt_u, q_u);
        end
        step();
        drive(1'b1, 4'd4, 1'b1, 4'd4, 1'b0);
        checks++;
        if (cnt_u !== 3'd2 || q_u !== 5'd4) begin
            errors++;
            $display("FAIL push_pop_same: count=%0d head=%0d, want 2/4", cnt_u, q_u);
        end
        step();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        checks++;
        if (cnt_u !== 3'd3) begin
            errors++;
            $display("FAIL pre_reset_count: count=%0d, want 3", cnt_u);
        end
        reset = 1'b1;
        drive(1'b1, 4'd5, 1'b1, 4'd5, 1'b1);
        checks++;
        if ({r1_u, r2_u} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready: got %b%b want 00", r1_u, r2_u);
        end
        step();
        checks++;
        if (cnt_u !== 3'd0 || v_u !== 1'b0 || q_u !== 5'd0) begin
            errors++;
            $display("FAIL mid_reset: count=%0d valid=%b data=%0d, want 0/0/0", cnt_u, v_u, q_u);
        end
        reset = 1'b0;
        drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        step();
    endtask

    initial begin
        d1_valid = 1'b0; d2_valid = 1'b0; out_ready = 1'b0;
        d1 = '0; d2 = '0; reset = 1'b1;
        test_reset();
        test_unsigned_add();
        test_signed_add();
        test_join();
        test_full_and_drain();
        test_back_to_back_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
